npxl_bar_driver: RTL and testbench

//   Downstream of the UART level receiver in the VU meter. Turns an 8-bit level value into a
//   WS2812 (NeoPixel) bar-graph frame on a single serial data line. Lit LEDs are green, then

---
 rtl/npxl_bar_driver_if.sv | 30 +++
 rtl/npxl_bar_driver.sv | 175 +++++++++++++++++
 tb/tb_npxl_bar_driver.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npxl_bar_driver_if.sv
// rtl/npxl_bar_driver_if.sv - level request / NeoPixel output bundle for the bar driver
//
// Purpose: groups the level strobe handshake and the serial data line of
//          npxl_bar_driver so they travel together.
// Signals:
//   i_level        8  requested bar level (number of lit LEDs)
//   i_level_valid  1  one-cycle strobe qualifying i_level
//   o_npxl_data    1  WS2812 serial data
//   o_rdy          1  high when the driver is idle with no request pending
// Modports: master = level source (testbench / UART side), slave = driver.
interface npxl_bar_driver_if;
  logic [7:0] i_level;
  logic       i_level_valid;
  logic       o_npxl_data;
  logic       o_rdy;

  modport master (
    output i_level,
    output i_level_valid,
    input  o_npxl_data,
    input  o_rdy
  );

  modport slave (
    input  i_level,
    input  i_level_valid,
    output o_npxl_data,
    output o_rdy
  );
endinterface

// File: rtl/npxl_bar_driver.sv
// rtl/npxl_bar_driver.sv - WS2812 bar-graph frame generator driven by a level strobe
//
// Purpose: turns an 8-bit level into one WS2812 frame of NUM_LEDS GRB words
//          (green, then yellow, then red toward the top; unlit LEDs off),
//          followed by a TRESET-cycle low latch gap.
// Ports:
//   i_clk    in   system clock
//   i_rst_n  in   asynchronous active-low reset; abandons any frame, line low
//   bus      slave modport of npxl_bar_driver_if (level strobe in, data/rdy out)
module npxl_bar_driver #(
  parameter int          NUM_LEDS    = 20,
  parameter int          GREEN_LEDS  = 12,
  parameter int          YELLOW_LEDS = 5,
  parameter logic [7:0]  BRIGHT      = 8'h10,
  parameter int          T0H         = 20,
  parameter int          T1H         = 40,
  parameter int          TBIT        = 63,
  parameter int          TRESET      = 3000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  npxl_bar_driver_if.slave   bus
);

  localparam int LED_W = $clog2(NUM_LEDS);

  localparam logic [5:0]       CNT_LAST  = 6'(TBIT - 1);
  localparam logic [5:0]       T0H_C     = 6'(T0H);
  localparam logic [5:0]       T1H_C     = 6'(T1H);
  localparam logic [11:0]      LCNT_LAST = 12'(TRESET - 1);
  localparam logic [LED_W-1:0] LED_LAST  = LED_W'(NUM_LEDS - 1);
  localparam logic [7:0]       NUM_C     = 8'(NUM_LEDS);
  localparam logic [7:0]       GREEN_C   = 8'(GREEN_LEDS);
  localparam logic [7:0]       YEL_END_C = 8'(GREEN_LEDS + YELLOW_LEDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BIT,
    S_LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       lvl_q, lvl_d;
  logic             pend_q, pend_d;
  logic [7:0]       pend_lvl_q, pend_lvl_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [4:0]       bit_q, bit_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [11:0]      lcnt_q, lcnt_d;
  logic [23:0]      shreg_q, shreg_d;
  logic             data_q, data_d;
  logic             rdy_q, rdy_d;

  function automatic logic [7:0] sat_level(input logic [7:0] l);
    return (l > NUM_C) ? NUM_C : l;
  endfunction

  // GRB word for one LED given the captured (already saturated) level.
  function automatic logic [23:0] led_word(input logic [LED_W-1:0] idx,
                                           input logic [7:0]       lvl);
    logic [7:0] i8;
    i8 = 8'(idx);
    if (i8 >= lvl)            return 24'h000000;
    else if (i8 < GREEN_C)    return {BRIGHT, 8'h00, 8'h00};
    else if (i8 < YEL_END_C)  return {BRIGHT, BRIGHT, 8'h00};
    else                      return {8'h00, BRIGHT, 8'h00};
  endfunction

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    pend_d     = pend_q;
    pend_lvl_d = pend_lvl_q;
    led_d      = led_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    lcnt_d     = lcnt_q;
    shreg_d    = shreg_q;

    // Requests arriving while busy are parked; a later one overwrites an earlier one.
    if (bus.i_level_valid && (state_q != S_IDLE)) begin
      pend_d     = 1'b1;
      pend_lvl_d = bus.i_level;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_level_valid) begin
          lvl_d   = sat_level(bus.i_level);
          led_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d = led_word(led_q, lvl_q);
        bit_d   = 5'd23;
        cnt_d   = 6'd0;
        state_d = S_BIT;
      end
      S_BIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = 6'd0;
          if (bit_q != 5'd0) begin
            shreg_d = {shreg_q[22:0], 1'b0};
            bit_d   = bit_q - 5'd1;
          end else if (led_q != LED_LAST) begin
            // Next LED's word loads straight into the shifter: no inter-LED gap.
            led_d   = led_q + 1'b1;
            shreg_d = led_word(led_q + 1'b1, lvl_q);
            bit_d   = 5'd23;
          end else begin
            lcnt_d  = 12'd0;
            state_d = S_LATCH;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_LATCH: begin
        if (lcnt_q == LCNT_LAST) begin
          if (pend_q || bus.i_level_valid) begin
            // A strobe landing in this very cycle is newer than the parked one.
            lvl_d   = sat_level(bus.i_level_valid ? bus.i_level : pend_lvl_q);
            pend_d  = 1'b0;
            led_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          lcnt_d = lcnt_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from next-state values so the registered copies
    // line up with the registered counters.
    data_d = (state_d == S_BIT) && (cnt_d < (shreg_d[23] ? T1H_C : T0H_C));
    rdy_d  = (state_d == S_IDLE) && !pend_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      lvl_q      <= 8'd0;
      pend_q     <= 1'b0;
      pend_lvl_q <= 8'd0;
      led_q      <= '0;
      bit_q      <= 5'd0;
      cnt_q      <= 6'd0;
      lcnt_q     <= 12'd0;
      shreg_q    <= 24'd0;
      data_q     <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      pend_q     <= pend_d;
      pend_lvl_q <= pend_lvl_d;
      led_q      <= led_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      lcnt_q     <= lcnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      rdy_q      <= rdy_d;
    end
  end

  assign bus.o_npxl_data = data_q;
  assign bus.o_rdy       = rdy_q;

endmodule

// File: tb/tb_npxl_bar_driver.sv
// tb/tb_npxl_bar_driver.sv - directed self-checking bench for npxl_bar_driver
module tb_npxl_bar_driver;

  localparam int NL        = 20;
  localparam int T0H       = 4;
  localparam int T1H       = 8;
  localparam int TBIT      = 13;
  localparam int TRESET    = 300;
  // 1 load cycle + 20*24 bits * 13 cycles + 300 latch cycles
  localparam int FRAME_CYC = 6541;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  npxl_bar_driver_if bus ();

  npxl_bar_driver #(
    .NUM_LEDS(NL), .GREEN_LEDS(12), .YELLOW_LEDS(5), .BRIGHT(8'h10),
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] cap [NL];
  int          cap_ok;
  int          cap_bad_hi;
  int          cap_bad_per;

  function automatic logic [23:0] exp_word(input int idx, input int lvl);
    int l;
    l = (lvl > NL) ? NL : lvl;
    if (idx >= l)      return 24'h000000;
    else if (idx < 12) return 24'h100000;
    else if (idx < 17) return 24'h101000;
    else               return 24'h001000;
  endfunction

  task automatic send_level(input logic [7:0] lv);
    @(posedge clk);
    #1;
    bus.i_level       = lv;
    bus.i_level_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_level_valid = 1'b0;
  endtask

  task automatic capture_frame(input int start_limit);
    int t, hi, lo;
    cap_ok = 0;
    cap_bad_hi = 0;
    cap_bad_per = 0;
    t = 0;
    while (bus.o_npxl_data !== 1'b1 && t < start_limit) begin
      @(negedge clk);
      t++;
    end
    if (bus.o_npxl_data !== 1'b1) return;
    for (int led = 0; led < NL; led++) begin
      cap[led] = 24'h0;
      for (int b = 0; b < 24; b++) begin
        hi = 0;
        while (bus.o_npxl_data === 1'b1 && hi < 100) begin
          hi++;
          @(negedge clk);
        end
        if (hi != T0H && hi != T1H) cap_bad_hi++;
        cap[led] = {cap[led][22:0], (hi == T1H)};
        if (!(led == NL - 1 && b == 23)) begin
          lo = 0;
          while (bus.o_npxl_data === 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
          end
          if (hi + lo != TBIT) cap_bad_per++;
        end
      end
    end
    cap_ok = 1;
  endtask

  task automatic check_frame(input string nm, input int lvl);
    n_tests++;
    if (cap_ok != 1) begin
      n_fail++;
      $display("FAIL %s frame_start: got no frame, want a frame", nm);
      return;
    end
    for (int i = 0; i < NL; i++) begin
      n_tests++;
      if (cap[i] !== exp_word(i, lvl)) begin
        n_fail++;
        $display("FAIL %s led%0d: got %06h want %06h", nm, i, cap[i], exp_word(i, lvl));
      end
    end
    n_tests++;
    if (cap_bad_hi != 0) begin
      n_fail++;
      $display("FAIL %s high_widths: got %0d bad pulses want 0", nm, cap_bad_hi);
    end
    n_tests++;
    if (cap_bad_per != 0) begin
      n_fail++;
      $display("FAIL %s bit_periods: got %0d bad periods want 0", nm, cap_bad_per);
    end
  endtask

  task automatic wait_rdy(input string nm, input int limit);
    int t;
    t = 0;
    while (bus.o_rdy !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (bus.o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rdy_timeout: got rdy=%b want 1", nm, bus.o_rdy);
    end
  endtask

  task automatic quiet_check(input string nm, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.o_npxl_data !== 1'b0 || bus.o_rdy !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s idle_hold: got %0d bad cycles want 0", nm, bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_level = 8'd0;
    bus.i_level_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.o_npxl_data !== 1'b0 || bus.o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: got data=%b rdy=%b want data=0 rdy=1",
               bus.o_npxl_data, bus.o_rdy);
    end
    rst_n = 1'b1;
    quiet_check("reset_no_strobe", 200);
  endtask

  task automatic test_level3();
    int low_cnt;
    low_cnt = 0;
    send_level(8'd3);
    fork
      capture_frame(100);
      begin
        while (low_cnt < 40000) begin
          @(negedge clk);
          if (bus.o_rdy !== 1'b0) break;
          low_cnt++;
        end
      end
    join
    check_frame("level3", 3);
    n_tests++;
    if (low_cnt != FRAME_CYC) begin
      n_fail++;
      $display("FAIL level3 rdy_low_cycles: got %0d want %0d", low_cnt, FRAME_CYC);
    end
    wait_rdy("level3", 100);
  endtask

  task automatic test_single(input string nm, input logic [7:0] lv, input int exp_lvl);
    send_level(lv);
    capture_frame(100);
    check_frame(nm, exp_lvl);
    wait_rdy(nm, 2 * FRAME_CYC);
  endtask

  task automatic test_back_to_back();
    send_level(8'd11);
    fork
      begin
        capture_frame(100);
        check_frame("b2b_first", 11);
        capture_frame(FRAME_CYC);
        check_frame("b2b_second", 5);
      end
      begin
        repeat (500) @(negedge clk);
        send_level(8'd7);
        repeat (500) @(negedge clk);
        send_level(8'd5);
      end
    join
    wait_rdy("b2b", 2 * FRAME_CYC);
    quiet_check("b2b_no_third", 2 * TRESET + 200);
  endtask

  task automatic test_reset_midframe();
    int t;
    send_level(8'd20);
    repeat (500) @(negedge clk);
    send_level(8'd9);
    repeat (FRAME_CYC + 100) @(negedge clk);
    t = 0;
    while (bus.o_npxl_data !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_tests++;
    if (bus.o_npxl_data !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid frame2_high: got data=%b want 1", bus.o_npxl_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.o_npxl_data !== 1'b0 || bus.o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid async: got data=%b rdy=%b want data=0 rdy=1",
               bus.o_npxl_data, bus.o_rdy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet_check("rst_mid_pending_cleared", 2 * TRESET + 200);
    test_single("rst_mid_after", 8'd17, 17);
  endtask

  initial begin
    test_reset();
    test_level3();
    test_single("level20", 8'd20, 20);
    test_single("level200", 8'd200, 20);
    test_single("level0", 8'd0, 0);
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
